// File: rtl/sram_arbiter.sv
// rtl/sram_arbiter.sv - CPU/GPU arbiter and SETUP/ACCESS/HOLD sequencer for a 16-bit async SRAM (option macro: SRAM_ARB_RR_EN)
module sram_arbiter #(
   parameter int unsigned WAIT_CYCLES = 1
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        cpu_req,
   input  logic        cpu_write,
   input  logic [15:0] cpu_addr,
   input  logic [15:0] cpu_wdata,
   input  logic [1:0]  cpu_be,
   output logic        cpu_ack,
   output logic [15:0] cpu_rdata,
   input  logic        gpu_req,
   input  logic        gpu_write,
   input  logic [15:0] gpu_addr,
   input  logic [15:0] gpu_wdata,
   input  logic [1:0]  gpu_be,
   output logic        gpu_ack,
   output logic [15:0] gpu_rdata,
   output logic        CE,
   output logic        OE,
   output logic        WR,
   output logic        UB,
   output logic        LB,
   output logic [15:0] A,
   output logic [15:0] D_out,
   output logic        D_oe,
   input  logic [15:0] D_in,
   output logic        busy
);

   typedef enum logic [1:0] {S_IDLE, S_SETUP, S_ACCESS, S_HOLD} state_t;

   localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

   state_t      state, next_state;
   logic [3:0]  wait_cnt;
   logic        any_req, win_id;
   logic        lat_id, lat_write;
   logic [15:0] lat_addr, lat_wdata;
   logic [1:0]  lat_be;
   logic        sel_write;
   logic [15:0] sel_addr, sel_wdata;
   logic [1:0]  sel_be;
   logic        ce_d, oe_d, wr_d, ub_d, lb_d, doe_d, cpu_ack_d, gpu_ack_d;
   logic [15:0] a_d, dout_d;

   assign any_req = cpu_req | gpu_req;
   assign busy    = (state != S_IDLE);

`ifdef SRAM_ARB_RR_EN
   logic last_gpu;

   // On a tie the requester that was not granted last wins
   always_comb begin
      win_id = gpu_req & ~cpu_req;
      if (cpu_req && gpu_req) win_id = ~last_gpu;
   end

   // Remember who was granted last; reset points at the GPU so the CPU wins the first tie
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                          last_gpu <= 1'b1;
      else if (state == S_IDLE && any_req) last_gpu <= win_id;
   end
`else
   // Fixed priority: the CPU wins every tie
   assign win_id = gpu_req & ~cpu_req;
`endif

   // In IDLE the winner's live fields feed the output decode, afterwards the latched copy does
   always_comb begin
      sel_write = lat_write;
      sel_addr  = lat_addr;
      sel_wdata = lat_wdata;
      sel_be    = lat_be;
      if (state == S_IDLE) begin
         sel_write = win_id ? gpu_write : cpu_write;
         sel_addr  = win_id ? gpu_addr  : cpu_addr;
         sel_wdata = win_id ? gpu_wdata : cpu_wdata;
         sel_be    = win_id ? gpu_be    : cpu_be;
      end
   end

   // Capture the granted request; later changes on the request fields are ignored
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         lat_id    <= 1'b0;
         lat_write <= 1'b0;
         lat_addr  <= '0;
         lat_wdata <= '0;
         lat_be    <= '0;
      end else if (state == S_IDLE && any_req) begin
         lat_id    <= win_id;
         lat_write <= sel_write;
         lat_addr  <= sel_addr;
         lat_wdata <= sel_wdata;
         lat_be    <= sel_be;
      end
   end

   // State register
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) state <= S_IDLE;
      else        state <= next_state;
   end

   // Access-length counter, loaded in SETUP and counted down through ACCESS
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N)                                       wait_cnt <= '0;
      else if (state == S_SETUP)                        wait_cnt <= WAIT_LOAD;
      else if (state == S_ACCESS && wait_cnt != 4'd0)   wait_cnt <= wait_cnt - 4'd1;
   end

   // Next-state logic
   always_comb begin
      next_state = state;
      case (state)
         S_IDLE:   if (any_req) next_state = S_SETUP;
         S_SETUP:  next_state = S_ACCESS;
         S_ACCESS: if (wait_cnt == 4'd0) next_state = S_HOLD;
         S_HOLD:   next_state = S_IDLE;
         default:  next_state = S_IDLE;
      endcase
   end

   // Output decode of the state being entered, so the pins change exactly on the state edge
   always_comb begin
      ce_d      = 1'b1;
      oe_d      = 1'b1;
      wr_d      = 1'b1;
      ub_d      = 1'b1;
      lb_d      = 1'b1;
      doe_d     = 1'b0;
      a_d       = A;
      dout_d    = D_out;
      cpu_ack_d = 1'b0;
      gpu_ack_d = 1'b0;
      if (next_state != S_IDLE) begin
         ce_d  = 1'b0;
         a_d   = sel_addr;
         ub_d  = ~sel_be[1];
         lb_d  = ~sel_be[0];
         doe_d = sel_write;
         if (sel_write) dout_d = sel_wdata;
      end
      if (next_state == S_SETUP || next_state == S_ACCESS) oe_d = sel_write;
      if (next_state == S_ACCESS) wr_d = ~sel_write;
      if (next_state == S_HOLD) begin
         cpu_ack_d = ~lat_id;
         gpu_ack_d = lat_id;
      end
   end

   // Registered SRAM pins and acknowledges
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         CE      <= 1'b1;
         OE      <= 1'b1;
         WR      <= 1'b1;
         UB      <= 1'b1;
         LB      <= 1'b1;
         D_oe    <= 1'b0;
         A       <= '0;
         D_out   <= '0;
         cpu_ack <= 1'b0;
         gpu_ack <= 1'b0;
      end else begin
         CE      <= ce_d;
         OE      <= oe_d;
         WR      <= wr_d;
         UB      <= ub_d;
         LB      <= lb_d;
         D_oe    <= doe_d;
         A       <= a_d;
         D_out   <= dout_d;
         cpu_ack <= cpu_ack_d;
         gpu_ack <= gpu_ack_d;
      end
   end

   // Sample read data on the last ACCESS cycle into the granted requester only, disabled lanes zeroed
   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cpu_rdata <= '0;
         gpu_rdata <= '0;
      end else if (state == S_ACCESS && wait_cnt == 4'd0 && !lat_write) begin
         if (lat_id) gpu_rdata <= D_in & {{8{lat_be[1]}}, {8{lat_be[0]}}};
         else        cpu_rdata <= D_in & {{8{lat_be[1]}}, {8{lat_be[0]}}};
      end
   end

endmodule

// File: tb/tb_sram_arbiter.sv
// tb/tb_sram_arbiter.sv - scoreboard bench for sram_arbiter with an SRAM device model and a memory reference model
module tb_sram_arbiter;

   localparam int MW = 1;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        cpu_req, cpu_write, gpu_req, gpu_write;
   logic [15:0] cpu_addr, cpu_wdata, gpu_addr, gpu_wdata;
   logic [1:0]  cpu_be, gpu_be;
   logic        cpu_ack, gpu_ack;
   logic [15:0] cpu_rdata, gpu_rdata;
   logic        CE, OE, WR, UB, LB, D_oe, busy;
   logic [15:0] A, D_out, D_in;

   logic        c3_req;
   logic        c3_ack, g3_ack, CE3, OE3, WR3, UB3, LB3, D_oe3, busy3;
   logic [15:0] c3_rdata, g3_rdata, A3, D_out3;

   always #5 CLK = ~CLK;

   sram_arbiter #(.WAIT_CYCLES(MW)) dut (
      .CLK(CLK), .RST_N(RST_N),
      .cpu_req(cpu_req), .cpu_write(cpu_write), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
      .cpu_be(cpu_be), .cpu_ack(cpu_ack), .cpu_rdata(cpu_rdata),
      .gpu_req(gpu_req), .gpu_write(gpu_write), .gpu_addr(gpu_addr), .gpu_wdata(gpu_wdata),
      .gpu_be(gpu_be), .gpu_ack(gpu_ack), .gpu_rdata(gpu_rdata),
      .CE(CE), .OE(OE), .WR(WR), .UB(UB), .LB(LB), .A(A), .D_out(D_out), .D_oe(D_oe),
      .D_in(D_in), .busy(busy)
   );

   sram_arbiter #(.WAIT_CYCLES(3)) dut3 (
      .CLK(CLK), .RST_N(RST_N),
      .cpu_req(c3_req), .cpu_write(1'b1), .cpu_addr(16'h0042), .cpu_wdata(16'h5A5A),
      .cpu_be(2'b11), .cpu_ack(c3_ack), .cpu_rdata(c3_rdata),
      .gpu_req(1'b0), .gpu_write(1'b0), .gpu_addr(16'h0000), .gpu_wdata(16'h0000),
      .gpu_be(2'b00), .gpu_ack(g3_ack), .gpu_rdata(g3_rdata),
      .CE(CE3), .OE(OE3), .WR(WR3), .UB(UB3), .LB(LB3), .A(A3), .D_out(D_out3), .D_oe(D_oe3),
      .D_in(16'h0000), .busy(busy3)
   );

   // external SRAM device
   bit [15:0] sram_mem [0:65535];
   always @(posedge CLK) begin
      if (!CE && !WR && D_oe) begin
         if (!UB) sram_mem[A][15:8] <= D_out[15:8];
         if (!LB) sram_mem[A][7:0]  <= D_out[7:0];
      end
   end
   assign D_in = (!CE && !OE) ? sram_mem[A] : 16'h0BAD;

   // reference model and scoreboard
   typedef struct { int id; bit rd; logic [15:0] data; } exp_t;
   exp_t      sb[$];
   exp_t      mon_e;
   bit [15:0] ref_mem [0:65535];
   bit [15:0] exp_rd [2];
   bit        last_gnt;
   int        checks = 0;
   int        errors = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   // arbitration rule: lone requester wins; ties go to CPU, or to whoever was not granted last
   function automatic int pick(input bit c, input bit g);
      int w;
      if (c && g) begin
`ifdef SRAM_ARB_RR_EN
         w = last_gnt ? 0 : 1;
`else
         w = 0;
`endif
      end else begin
         w = c ? 0 : 1;
      end
      last_gnt = (w == 1);
      return w;
   endfunction

   task automatic set_fields(input int id, input bit wr, input logic [15:0] ad, input logic [15:0] wd,
                             input logic [1:0] be);
      if (id == 0) begin cpu_write = wr; cpu_addr = ad; cpu_wdata = wd; cpu_be = be; end
      else         begin gpu_write = wr; gpu_addr = ad; gpu_wdata = wd; gpu_be = be; end
   endtask

   // apply the requester's current transaction to the reference memory and queue its response
   task automatic expect_txn(input int id);
      bit          wr;
      logic [15:0] ad, wd;
      logic [1:0]  be;
      exp_t        e;
      if (id == 0) begin wr = cpu_write; ad = cpu_addr; wd = cpu_wdata; be = cpu_be; end
      else         begin wr = gpu_write; ad = gpu_addr; wd = gpu_wdata; be = gpu_be; end
      e.id = id; e.rd = !wr; e.data = 16'h0000;
      if (wr) begin
         if (be[1]) ref_mem[ad][15:8] = wd[15:8];
         if (be[0]) ref_mem[ad][7:0]  = wd[7:0];
      end else begin
         e.data = {be[1] ? ref_mem[ad][15:8] : 8'h00, be[0] ? ref_mem[ad][7:0] : 8'h00};
      end
      sb.push_back(e);
   endtask

   // monitor: every ack pops one expectation and checks both rdata registers
   always @(negedge CLK) begin
      if (RST_N === 1'b1 && (cpu_ack || gpu_ack)) begin
         chk("ack_onehot", {31'd0, cpu_ack & gpu_ack}, 0);
         chk("sb_has_entry", sb.size() != 0, 1);
         if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("ack_id", {31'd0, gpu_ack}, mon_e.id);
            if (mon_e.rd) exp_rd[mon_e.id] = mon_e.data;
            chk("cpu_rdata", cpu_rdata, exp_rd[0]);
            chk("gpu_rdata", gpu_rdata, exp_rd[1]);
         end
      end
   end

   // single transaction with cycle-by-cycle pin checks relative to the request cycle T
   task automatic timed(input int id, input bit wr, input logic [15:0] ad, input logic [15:0] wd,
                        input logic [1:0] be);
      bit ack_i, in_t, acc;
      set_fields(id, wr, ad, wd, be);
      expect_txn(pick(id == 0, id == 1));
      if (id == 0) cpu_req = 1'b1; else gpu_req = 1'b1;
      for (int j = 1; j <= 3 + MW; j++) begin
         @(negedge CLK);
         in_t  = (j <= 2 + MW);
         acc   = (j >= 2 && j <= 1 + MW);
         ack_i = (id == 0) ? cpu_ack : gpu_ack;
         chk($sformatf("CE@T+%0d", j), CE, !in_t);
         chk($sformatf("WR@T+%0d", j), WR, !(wr && acc));
         chk($sformatf("OE@T+%0d", j), OE, !(!wr && j <= 1 + MW));
         chk($sformatf("D_oe@T+%0d", j), D_oe, wr && in_t);
         chk($sformatf("ack@T+%0d", j), ack_i, j == 2 + MW);
         chk($sformatf("busy@T+%0d", j), busy, in_t);
         if (in_t) begin
            chk($sformatf("A@T+%0d", j), A, ad);
            chk($sformatf("UB@T+%0d", j), UB, !be[1]);
            chk($sformatf("LB@T+%0d", j), LB, !be[0]);
            if (wr) chk($sformatf("D_out@T+%0d", j), D_out, wd);
         end
         if (ack_i) begin cpu_req = 1'b0; gpu_req = 1'b0; end
      end
      cpu_req = 1'b0; gpu_req = 1'b0;
   endtask

   // issue from one or both requesters, drop each request after its ack
   task automatic run(input bit c, input bit g);
      int first, second, cnt;
      bit c_done, g_done;
      first = pick(c, g);
      expect_txn(first);
      if (c && g) begin
         second = pick(first == 1, first == 0);
         expect_txn(second);
      end
      cpu_req = c; gpu_req = g;
      c_done = !c; g_done = !g; cnt = 0;
      while (!(c_done && g_done) && cnt < 40) begin
         @(negedge CLK);
         cnt++;
         if (cpu_ack) begin cpu_req = 1'b0; c_done = 1'b1; end
         if (gpu_ack) begin gpu_req = 1'b0; g_done = 1'b1; end
      end
      chk("run_all_acked", c_done && g_done, 1);
      cpu_req = 1'b0; gpu_req = 1'b0;
   endtask

   initial begin
      int n, cnt, low, ack_at, mode;
      RST_N = 1'b0; cpu_req = 1'b0; gpu_req = 1'b0; c3_req = 1'b0;
      set_fields(0, 1'b0, 16'h0, 16'h0, 2'b00);
      set_fields(1, 1'b0, 16'h0, 16'h0, 2'b00);
      last_gnt = 1'b1;
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0;
      repeat (3) @(negedge CLK);
      chk("rst_strobes", {CE, OE, WR, UB, LB}, 5'b11111);
      chk("rst_A", A, 0);
      chk("rst_D_out", D_out, 0);
      chk("rst_D_oe", D_oe, 0);
      chk("rst_acks", {cpu_ack, gpu_ack}, 0);
      chk("rst_cpu_rdata", cpu_rdata, 0);
      chk("rst_gpu_rdata", gpu_rdata, 0);
      chk("rst_busy", busy, 0);
      RST_N = 1'b1;
      @(negedge CLK);

      // directed transactions with pin timing
      timed(0, 1'b1, 16'h1234, 16'hBEEF, 2'b11);
      timed(0, 1'b0, 16'h1234, 16'h0000, 2'b11);
      timed(0, 1'b1, 16'h2000, 16'hA55A, 2'b11);
      timed(1, 1'b0, 16'h2000, 16'h0000, 2'b10);
      timed(0, 1'b0, 16'h1234, 16'h0000, 2'b00);

      // both requesters held across several grants
      set_fields(0, 1'b0, 16'h1234, 16'h0000, 2'b11);
      set_fields(1, 1'b0, 16'h2000, 16'h0000, 2'b11);
      for (int k = 0; k < 4; k++) expect_txn(pick(1'b1, 1'b1));
      cpu_req = 1'b1; gpu_req = 1'b1; n = 0; cnt = 0;
      while (n < 4 && cnt < 60) begin
         @(negedge CLK);
         cnt++;
         if (cpu_ack || gpu_ack) n++;
      end
      cpu_req = 1'b0; gpu_req = 1'b0;
      chk("held_ack_count", n, 4);
      @(negedge CLK);

      // longer access: write on the WAIT_CYCLES=3 instance
      c3_req = 1'b1; low = 0; ack_at = 0;
      for (int j = 1; j <= 7; j++) begin
         @(negedge CLK);
         if (!WR3) low++;
         chk($sformatf("w3_WR@T+%0d", j), WR3, !(j >= 2 && j <= 4));
         if (c3_ack) begin
            if (ack_at == 0) ack_at = j;
            c3_req = 1'b0;
         end
      end
      c3_req = 1'b0;
      chk("w3_wr_low_cycles", low, 3);
      chk("w3_ack_cycle", ack_at, 5);

      // reset in the middle of a write access
      set_fields(0, 1'b1, 16'h3000, 16'h1111, 2'b11);
      cpu_req = 1'b1;
      @(negedge CLK);
      @(negedge CLK);
      chk("abort_in_access", WR, 0);
      #2 RST_N = 1'b0;
      #1;
      chk("abort_strobes", {CE, OE, WR, UB, LB}, 5'b11111);
      chk("abort_D_oe", D_oe, 0);
      chk("abort_busy", busy, 0);
      chk("abort_cpu_rdata", cpu_rdata, 0);
      chk("abort_gpu_rdata", gpu_rdata, 0);
      exp_rd[0] = 16'h0; exp_rd[1] = 16'h0; last_gnt = 1'b1;
      cpu_req = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      for (int j = 0; j < 5; j++) begin
         @(negedge CLK);
         chk("abort_no_ack", cpu_ack, 0);
      end
      timed(0, 1'b0, 16'h3000, 16'h0000, 2'b11);

      // randomized traffic over a small address window
      for (int i = 0; i < 40; i++) begin
         mode = $urandom_range(0, 2);
         set_fields(0, 1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
         set_fields(1, 1'($urandom_range(0, 1)), 16'h4000 + 16'($urandom_range(0, 15)), 16'($urandom), 2'($urandom));
         run(mode != 1, mode != 0);
         if ($urandom_range(0, 1) == 1) @(negedge CLK);
      end

      repeat (4) @(negedge CLK);
      chk("sb_drained", sb.size(), 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not complete, %0d checks, %0d errors", checks, errors);
      $fatal(1);
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter and cycle sequencer for the external 16-bit asynchronous SRAM. Requester 0 is the CPU memory path and requester 1 is the GPU/video fetch path. The block grants one requester at a time and latches that request. It then drives the SRAM strobes (CE, OE, WR, UB, LB), address and data through a fixed setup/access/hold sequence, and returns read data with a one-cycle acknowledge. It sits between the RAM-side memory bus and the SRAM pins. The split data pins (D_out / D_oe / D_in) keep the design simulable without tristates.

## Interface
- `WAIT_CYCLES`, 1: number of ACCESS-state cycles per transaction. Legal range 1..15.
- `CLK`  in  1  system clock, all logic on the rising edge.
- `RST_N`  in  1  asynchronous active-low reset.
- `cpu_req` / `gpu_req`  in  1  request. Must be held, with its fields stable, until the matching ack.
- `cpu_write` / `gpu_write`  in  1  1 = write, 0 = read.
- `cpu_addr` / `gpu_addr`  in  16  word address.
- `cpu_wdata` / `gpu_wdata`  in  16  write data.
- `cpu_be` / `gpu_be`  in  2  byte enables. [1] = upper byte, [0] = lower byte; active high.
- `cpu_ack` / `gpu_ack`  out  1  one-cycle pulse on completion.
- `cpu_rdata` / `gpu_rdata`  out  16  read data, registered per requester.
- `CE`, `OE`, `WR`, `UB`, `LB`  out  1  SRAM strobes, all active low.
- `A`  out  16  SRAM address.
- `D_out`  out  16  data driven to the SRAM.
- `D_oe`  out  1  1 = pins drive D_out.
- `D_in`  in  16  data sampled from the SRAM.
- `busy`  out  1  high whenever state is not IDLE.

## Operation
- States: IDLE, SETUP, ACCESS, HOLD. Each state has a registered output decode.
- **IDLE**
  - If any request is present, select a winner per the arbitration rule.
  - Latch the winner's id, write, addr, wdata and be.
  - Go to SETUP. Without a request, stay in IDLE.
- **SETUP** (1 cycle)
  - CE=0, A=latched address.
  - UB=~be[1], LB=~be[0].
  - Read: OE=0. Write: D_oe=1, D_out=wdata, OE=1.
  - WR stays 1.
  - Load the wait counter with WAIT_CYCLES-1. Go to ACCESS.
- **ACCESS** (WAIT_CYCLES cycles)
  - Outputs as in SETUP, plus WR=0 for writes.
  - The counter decrements each cycle. At 0, go to HOLD.
  - Read: on the last ACCESS cycle, sample D_in into the granted requester's rdata. Disabled byte lanes are written as 0x00.
- **HOLD** (1 cycle)
  - WR=1 and OE=1. CE, A, UB/LB and (for writes) D_oe/D_out are held for hold time.
  - Pulse the granted requester's ack. Go to IDLE.
- rdata of the non-granted requester is never modified. rdata holds until that requester's next read.
- The requester's fields are sampled only in IDLE. Changes after grant have no effect.
- A requester still asserting req in the cycle after its ack is treated as a new request.
- be = 2'b00 still runs the full sequence with UB=LB=1 and returns ack. On a read, rdata becomes 0x0000.
- Arbitration default (macro absent): fixed priority, CPU wins every simultaneous request.

## Timing
- Reset values while RST_N=0 (asynchronous):
  - State IDLE.
  - CE=OE=WR=UB=LB=1.
  - A=0, D_out=0, D_oe=0.
  - cpu_ack=gpu_ack=0, cpu_rdata=gpu_rdata=0, busy=0.
  - Round-robin pointer = "GPU last".
- Request seen in IDLE at cycle T:
  - SETUP at T+1.
  - ACCESS from T+2 to T+1+WAIT_CYCLES.
  - HOLD with ack at T+2+WAIT_CYCLES.
  - rdata valid in the ack cycle.
- Latency from request to ack is 2+WAIT_CYCLES. The minimum period between grants is 3+WAIT_CYCLES cycles.
- A request arriving while busy waits. No request is lost while it is held.
- Reset asserted mid-transaction aborts the transaction: outputs go to reset values immediately, no ack is issued, and rdata is cleared.

## Configuration
- `SRAM_ARB_RR_EN` defined: round-robin arbitration.
  - A 1-bit last-grant pointer is updated on every grant.
  - On simultaneous requests, the requester not granted last wins. Reset pointer = GPU, so the CPU wins the first tie.
  - A lone requester is always granted.
- `SRAM_ARB_RR_EN` undefined: fixed CPU priority, and no pointer register is built.

## Test plan
- Reset, then CPU write addr 0x1234, data 0xBEEF, be 2'b11, WAIT_CYCLES=1 -> CE low T+1..T+3, WR low only at T+2, D_oe=1 T+1..T+3, cpu_ack pulse at T+3 only.
- CPU read addr 0x1234 with the SRAM model returning 0xBEEF -> OE low T+1..T+2, cpu_rdata=0xBEEF at the ack cycle, gpu_rdata unchanged at 0x0000.
- GPU read with be=2'b10 and SRAM data 0xA55A -> UB=0, LB=1, gpu_rdata=0xA500.
- CPU and GPU request in the same cycle, held continuously:
  - Fixed priority: CPU is acked repeatedly and the GPU never is.
  - With SRAM_ARB_RR_EN: acks alternate CPU, GPU, CPU.
- WAIT_CYCLES=3 write -> WR low for exactly 3 cycles, ack 5 cycles after the request.
- RST_N pulsed low during ACCESS of a write -> all strobes 1 and D_oe=0 within the same cycle, no ack ever issued, and the next request sequences normally.
